// File: rtl/uk101_boot_keys.sv
// Front-panel button conditioner and boot autotyper for the UK101 core.
// Synchronises and debounces the buttons, then plays reset, B, C, Enter x3 after every reset.
module uk101_boot_keys #(
  parameter int unsigned step_cycles     = 16777216,
  parameter int unsigned debounce_cycles = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_reset,
  input  logic btn_b,
  input  logic btn_c,
  input  logic btn_enter,
  input  logic autotype_en,
  output logic n_reset,
  output logic key_b,
  output logic key_c,
  output logic key_enter,
  output logic busy
);

  localparam int CW = (step_cycles > 1) ? $clog2(step_cycles) : 1;
  localparam int DW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(step_cycles - 1);
  localparam logic [DW-1:0] D_LAST = DW'(debounce_cycles - 1);

  localparam int BTN_RST = 0;
  localparam int BTN_B   = 1;
  localparam int BTN_C   = 2;
  localparam int BTN_ENT = 3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [3:0]      btn_raw_s;
  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [3:0]      db_q;
  logic [3:0]      db_d;
  logic [4*DW-1:0] dcnt_q;
  logic [4*DW-1:0] dcnt_d;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      s_q;
  logic [3:0]      s_d;
  logic [CW-1:0]   c_q;
  logic [CW-1:0]   c_d;

  logic            run_s;
  logic            n_reset_d;
  logic            key_b_d;
  logic            key_c_d;
  logic            key_enter_d;
  logic            busy_d;
  logic            n_reset_q;
  logic            key_b_q;
  logic            key_c_q;
  logic            key_enter_q;
  logic            busy_q;

  assign btn_raw_s = {btn_enter, btn_c, btn_b, btn_reset};

  // Two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw_s;
      sync2_q <= sync1_q;
    end
  end

  // A change is accepted only after debounce_cycles consecutive differing samples
  always_comb begin
    db_d   = db_q;
    dcnt_d = {(4*DW){1'b0}};
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i*DW +: DW] == D_LAST) begin
          db_d[i]            = ~db_q[i];
          dcnt_d[i*DW +: DW] = {DW{1'b0}};
        end else begin
          dcnt_d[i*DW +: DW] = dcnt_q[i*DW +: DW] + DW'(1);
        end
      end else begin
        dcnt_d[i*DW +: DW] = {DW{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q   <= 4'b0000;
      dcnt_q <= {(4*DW){1'b0}};
    end else begin
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
    end
  end

  // A held reset button overrides everything, including a coincident step wrap
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    if (db_q[BTN_RST]) begin
      state_d = ST_HOLD;
      s_d     = 4'd0;
      c_d     = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (c_q == C_LAST) begin
            c_d = {CW{1'b0}};
            if ((s_q == 4'd15) || ((s_q == 4'd0) && !autotype_en)) begin
              state_d = ST_DONE;
              s_d     = 4'd0;
            end else begin
              s_d = s_q + 4'd1;
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
        ST_HOLD: begin
          state_d = ST_RUN;
          s_d     = 4'd0;
          c_d     = {CW{1'b0}};
        end
        ST_DONE: begin
          state_d = ST_DONE;
          s_d     = s_q;
          c_d     = c_q;
        end
        default: begin
          state_d = ST_RUN;
          s_d     = 4'd0;
          c_d     = {CW{1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the step counter
  always_comb begin
    run_s       = (state_d == ST_RUN);
    n_reset_d   = ~((state_d == ST_HOLD) | (run_s & (s_d == 4'd0)));
    key_b_d     = (run_s & (s_d == 4'd2)) | db_q[BTN_B];
    key_c_d     = (run_s & (s_d == 4'd4)) | db_q[BTN_C];
    key_enter_d = (run_s & ((s_d == 4'd6) | (s_d == 4'd8) | (s_d == 4'd12))) | db_q[BTN_ENT];
    busy_d      = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      s_q         <= 4'd0;
      c_q         <= {CW{1'b0}};
      n_reset_q   <= 1'b0;
      key_b_q     <= 1'b0;
      key_c_q     <= 1'b0;
      key_enter_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      n_reset_q   <= n_reset_d;
      key_b_q     <= key_b_d;
      key_c_q     <= key_c_d;
      key_enter_q <= key_enter_d;
      busy_q      <= busy_d;
    end
  end

  assign n_reset   = n_reset_q;
  assign key_b     = key_b_q;
  assign key_c     = key_c_q;
  assign key_enter = key_enter_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uk101_boot_keys.sv
// Randomised and directed bench for uk101_boot_keys against a cycle-indexed behavioural model.
module tb_uk101_boot_keys;

  localparam int STEP = 8;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;
  logic       autotype_en = 1'b1;
  logic       n_reset, key_b, key_c, key_enter, busy;

  uk101_boot_keys #(.step_cycles(STEP), .debounce_cycles(DEB)) dut (
    .clk(clk), .reset(reset),
    .btn_reset(btns[0]), .btn_b(btns[1]), .btn_c(btns[2]), .btn_enter(btns[3]),
    .autotype_en(autotype_en),
    .n_reset(n_reset), .key_b(key_b), .key_c(key_c), .key_enter(key_enter), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;
  int anchor;
  bit hold_prev;
  bit done_m;
  bit raw_h [4][4096];
  bit db_h  [4][4096];

  function automatic bit raw_at(int b, int k);
    if (k < 0) return 1'b0;
    return raw_h[b][k];
  endfunction

  function automatic bit db_at(int b, int k);
    if (k < 0) return 1'b0;
    return db_h[b][k];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model: a button is seen DEB cycles after two sync cycles; the step is cycles since the last start / STEP.
  task automatic step_cycle();
    bit hold, run, prev, alldiff;
    int stp;
    bit e_nr, e_b, e_c, e_e, e_busy;
    for (int b = 0; b < 4; b++) begin
      prev    = db_at(b, n - 1);
      alldiff = 1'b1;
      for (int j = 3; j < 3 + DEB; j++)
        if (raw_at(b, n - j) == prev) alldiff = 1'b0;
      db_h[b][n] = alldiff ? !prev : prev;
    end
    hold = db_at(0, n - 1);
    if (!hold && hold_prev) begin
      anchor = n;
      done_m = 1'b0;
    end
    stp = (n - anchor) / STEP;
    if (!hold && !done_m && (stp >= 16 || (stp >= 1 && !autotype_en))) done_m = 1'b1;
    run    = !hold && !done_m;
    e_nr   = !(hold || (run && stp == 0));
    e_b    = (run && stp == 2) || db_at(1, n - 1);
    e_c    = (run && stp == 4) || db_at(2, n - 1);
    e_e    = (run && (stp == 6 || stp == 8 || stp == 12)) || db_at(3, n - 1);
    e_busy = hold || !done_m;
    hold_prev = hold;
    chk($sformatf("n_reset@%0d", n), n_reset, e_nr);
    chk($sformatf("key_b@%0d", n), key_b, e_b);
    chk($sformatf("key_c@%0d", n), key_c, e_c);
    chk($sformatf("key_enter@%0d", n), key_enter, e_e);
    chk($sformatf("busy@%0d", n), busy, e_busy);
    for (int b = 0; b < 4; b++) raw_h[b][n] = btns[b];
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) step_cycle();
  endtask

  task automatic press(input int b, input int dur, input int gap);
    btns[b] = 1'b1;
    run_cycles(dur);
    btns[b] = 1'b0;
    run_cycles(gap);
  endtask

  task automatic start_run(input bit ate);
    autotype_en = ate;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    n         = 0;
    anchor    = 0;
    hold_prev = 1'b0;
    done_m    = 1'b0;
  endtask

  task automatic async_reset_check();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_n_reset", n_reset, 1'b0);
    chk("arst_key_b", key_b, 1'b0);
    chk("arst_key_c", key_c, 1'b0);
    chk("arst_key_enter", key_enter, 1'b0);
    chk("arst_busy", busy, 1'b1);
  endtask

  initial begin
    // Full boot sequence with autotype enabled and no buttons
    start_run(1'b1);
    run_cycles(140);

    // Autotype disabled: only the power-on reset pulse, then manual keys in DONE
    start_run(1'b0);
    run_cycles(20);
    press(1, 3, 15);
    press(1, 20, 15);
    press(3, 30, 12);
    for (int k = 0; k < 15; k++)
      press($urandom_range(1, 3), $urandom_range(1, 12), $urandom_range(0, 10));
    run_cycles(12);

    // Reset button pressed mid-sequence, then the sequence replays
    start_run(1'b1);
    run_cycles(40);
    press(0, 30, 150);

    // Asynchronous reset during step 6, then random activity including the reset button
    start_run(1'b1);
    run_cycles(51);
    async_reset_check();
    start_run(1'b1);
    for (int k = 0; k < 20; k++)
      press($urandom_range(0, 3), $urandom_range(1, 40), $urandom_range(0, 20));
    run_cycles(140);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
